// File: rtl/fetch_stage.sv
// fetch_stage: fetch PC, single-outstanding imem handshake, skid buffer, F/D register.
// Ports: clk/rst_n, StallD/FlushD/PCSrcE/PCTargetE in; imem_* req/resp; InstrD/PCD/inc_PCD/fetch_busy out.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'hBFC00000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] inc_PCD,
  output logic        fetch_busy
);

  typedef enum logic {ACTIVE, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] saved_q, saved_d;
  logic [31:0] redir_q, redir_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] inc_q, inc_d;

  logic        xfer;
  logic        accept;
  logic        fd_ld;
  logic        fd_bub;
  logic [31:0] fd_instr;
  logic [31:0] fd_pc;
  logic [31:0] tgt;
  logic [31:0] pcf_inc;

  // Request is gated by rst_n so nothing is issued while held in reset.
  assign imem_req   = rst_n & ((state_q == DRAIN) | ~buf_valid_q);
  assign imem_addr  = (state_q == DRAIN) ? saved_q : pcf_q;
  assign xfer       = imem_req & imem_valid;
  assign fetch_busy = imem_req & ~imem_valid;
  assign accept     = ~StallD & ~FlushD;
  assign tgt        = {PCTargetE[31:2], 2'b00};
  assign pcf_inc    = pcf_q + 32'd4;

  assign InstrD  = instr_q;
  assign PCD     = pcd_q;
  assign inc_PCD = inc_q;

  always_comb begin
    state_d     = state_q;
    pcf_d       = pcf_q;
    buf_valid_d = buf_valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    saved_d     = saved_q;
    redir_d     = redir_q;
    fd_ld       = 1'b0;
    fd_bub      = 1'b0;
    fd_instr    = buf_instr_q;
    fd_pc       = buf_pc_q;

    if (PCSrcE) begin
      // Any response landing this cycle belongs to the wrong path.
      buf_valid_d = 1'b0;
      fd_bub      = 1'b1;
      if (imem_req && !imem_valid) begin
        saved_d = imem_addr;
        redir_d = tgt;
        state_d = DRAIN;
      end else begin
        pcf_d   = tgt;
        state_d = ACTIVE;
      end
    end else if (state_q == DRAIN) begin
      fd_bub = 1'b1;
      if (xfer) begin
        pcf_d   = redir_q;
        state_d = ACTIVE;
      end
    end else if (buf_valid_q) begin
      if (accept) begin
        fd_ld       = 1'b1;
        buf_valid_d = 1'b0;
      end
    end else if (xfer) begin
      pcf_d = pcf_inc;
      if (accept) begin
        fd_ld    = 1'b1;
        fd_instr = imem_rdata;
        fd_pc    = pcf_q;
      end else begin
        // Decode cannot take it: park it in the skid buffer.
        buf_valid_d = 1'b1;
        buf_instr_d = imem_rdata;
        buf_pc_d    = pcf_q;
      end
    end else begin
      fd_bub = 1'b1;
    end

    instr_d = instr_q;
    pcd_d   = pcd_q;
    inc_d   = inc_q;
    if (FlushD || (!StallD && fd_bub)) begin
      instr_d = NOP_INSTR;
    end else if (fd_ld) begin
      instr_d = fd_instr;
      pcd_d   = fd_pc;
      inc_d   = fd_pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACTIVE;
      pcf_q       <= RESET_PC;
      buf_valid_q <= 1'b0;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
      saved_q     <= '0;
      redir_q     <= '0;
      instr_q     <= NOP_INSTR;
      pcd_q       <= '0;
      inc_q       <= '0;
    end else begin
      state_q     <= state_d;
      pcf_q       <= pcf_d;
      buf_valid_q <= buf_valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      saved_q     <= saved_d;
      redir_q     <= redir_d;
      instr_q     <= instr_d;
      pcd_q       <= pcd_d;
      inc_q       <= inc_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized fetch stream vs program-order reference.
// Memory returns addr^K with random latency; decode stream checked per appearance.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'hBFC00000;
  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] K      = 32'h5A5A0001;

  logic        clk;
  logic        rst_n;
  logic        StallD;
  logic        FlushD;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] inc_PCD;
  logic        fetch_busy;

  fetch_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .inc_PCD    (inc_PCD),
    .fetch_busy (fetch_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Memory model
  int cnt;
  int lat;
  int lat_fix;
  bit lat_rand;
  bit spur;

  assign imem_valid = imem_req ? (cnt >= lat) : spur;
  assign imem_rdata = imem_addr ^ K;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 0;
      lat <= lat_fix;
    end else if (imem_req && imem_valid) begin
      cnt <= 0;
      lat <= lat_rand ? int'($urandom_range(0, 3)) : lat_fix;
    end else if (imem_req) begin
      cnt <= cnt + 1;
    end
  end

  // Scoreboard: redirects pushed by stimulus, consumed by the decode monitor.
  logic [31:0] rq[$];
  logic [31:0] exp_pc;
  logic [31:0] prev_instr;
  logic [31:0] prev_pcd;
  logic [31:0] prev_inc;
  int gap;
  int idle;
  int n_seen = 0;
  int exp_gap;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      exp_pc = RST_PC;
      rq.delete();
      prev_instr = NOP;
      prev_pcd = 32'h0;
      prev_inc = 32'h0;
      gap = 0;
      idle = 0;
    end else begin
      while (rq.size() > 0) exp_pc = rq.pop_front();
      gap++;
      idle++;
      if (InstrD != NOP && (InstrD != prev_instr || PCD != prev_pcd)) begin
        chk("pcd_order", PCD, exp_pc);
        chk("instr_data", InstrD, PCD ^ K);
        chk("inc_pcd", inc_PCD, PCD + 32'd4);
        if (exp_gap != 0) chk("issue_gap", 32'(gap), 32'(exp_gap));
        exp_pc = PCD + 32'd4;
        gap = 0;
        idle = 0;
        n_seen++;
      end else if (InstrD == NOP) begin
        chk("bubble_pcd", PCD, prev_pcd);
        chk("bubble_inc", inc_PCD, prev_inc);
      end
      if (idle > 200) begin
        checks++;
        $display("FAIL watchdog: no new instruction for %0d cycles", idle);
        idle = 0;
      end
      prev_instr = InstrD;
      prev_pcd = PCD;
      prev_inc = inc_PCD;
    end
  end

  // Handshake monitor
  bit prev_wait;
  logic [31:0] prev_addr;

  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      chk("req_in_reset", 32'(imem_req), 32'h0);
      prev_wait = 1'b0;
    end else begin
      chk("fetch_busy", 32'(fetch_busy), 32'(imem_req & ~imem_valid));
      chk("addr_align", 32'(imem_addr[1:0]), 32'h0);
      if (prev_wait && imem_req) chk("addr_hold", imem_addr, prev_addr);
      prev_wait = imem_req && !imem_valid;
      prev_addr = imem_addr;
    end
  end

  task automatic redirect(input logic [31:0] t);
    PCSrcE = 1'b1;
    FlushD = 1'b1;
    PCTargetE = t;
    rq.push_back({t[31:2], 2'b00});
  endtask

  initial begin
    rst_n = 1'b0;
    StallD = 1'b0;
    FlushD = 1'b0;
    PCSrcE = 1'b0;
    PCTargetE = 32'h0;
    spur = 1'b0;
    lat_fix = 0;
    lat_rand = 1'b0;
    exp_gap = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_instr", InstrD, NOP);
    chk("rst_pcd", PCD, 32'h0);
    chk("rst_inc", inc_PCD, 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("first_req", 32'(imem_req), 32'h1);
    chk("first_addr", imem_addr, RST_PC);
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      #1;
      chk("seq_addr", imem_addr, RST_PC + 32'(4 * i));
    end
    exp_gap = 1;
    repeat (20) @(negedge clk);
    exp_gap = 0;

    lat_fix = 3;
    repeat (10) @(negedge clk);
    exp_gap = 4;
    repeat (40) @(negedge clk);
    exp_gap = 0;

    lat_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      int r;
      @(negedge clk);
      spur = 1'($urandom);
      StallD = ($urandom % 100) < 30;
      PCSrcE = 1'b0;
      FlushD = 1'b0;
      r = int'($urandom % 100);
      if (r < 4) begin
        redirect(32'hBFC00000 | ($urandom & 32'h0000FFFF));
      end else if (r < 8) begin
        FlushD = 1'b1;
        StallD = 1'b1;
      end
    end
    @(negedge clk);
    StallD = 1'b0;
    redirect(32'hFFFFFFF2);
    @(negedge clk);
    PCSrcE = 1'b0;
    FlushD = 1'b0;
    lat_rand = 1'b0;
    lat_fix = 1;
    repeat (30) @(negedge clk);

    lat_fix = 3;
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_instr", InstrD, NOP);
    chk("async_pcd", PCD, 32'h0);
    chk("async_inc", inc_PCD, 32'h0);
    chk("async_req", 32'(imem_req), 32'h0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("refetch_addr", imem_addr, RST_PC);
    chk("refetch_req", 32'(imem_req), 32'h1);
    repeat (30) @(negedge clk);

    chk("seen_min", 32'(n_seen >= 300), 32'h1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
